// File: rtl/stb_arb_pkg.sv
// -----------------------------------------------------------------------------
// stb_arb_pkg
// Shared definitions for the burst_store -> axi_stb request arbiter.
//   arb_state_e          : arbiter FSM states
//   STB_BURST_LEN_W      : width of the beats-1 burst length field
//   STB_TIMEOUT_DEFAULT  : default WAIT_DONE watchdog limit (cycles)
//   id_width()           : grant-id width for a given requester count
// -----------------------------------------------------------------------------
package stb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } arb_state_e;

    localparam int STB_BURST_LEN_W     = 8;
    localparam int STB_TIMEOUT_DEFAULT = 4096;

    // A single requester still needs a 1-bit id so the grant port exists.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stb_rr_pick.sv
// -----------------------------------------------------------------------------
// stb_rr_pick
// Combinational round-robin picker. Scans req_valid starting at rr_ptr+1,
// wrapping modulo NUM_REQ, and returns the first requester found.
// Ports:
//   req_valid [NUM_REQ] in  : per-requester request
//   rr_ptr    [ID_W]    in  : last granted requester
//   found               out : at least one request is pending
//   winner    [ID_W]    out : selected requester (0 when found is low)
// -----------------------------------------------------------------------------
module stb_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               found,
    output logic [ID_W-1:0]    winner
);

    // Candidate gi is the requester at distance gi+1 from the pointer, so
    // candidate 0 is the highest-priority position in this round.
    logic [ID_W-1:0]    cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_vld;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign cand_idx[gi] = ID_W'((int'(rr_ptr) + gi + 1) % NUM_REQ);
            assign cand_vld[gi] = req_valid[cand_idx[gi]];
        end
    endgenerate

    // Walk from the lowest priority upward so the nearest candidate is the
    // last one written and therefore wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_vld[k]) begin
                found  = 1'b1;
                winner = cand_idx[k];
            end
        end
    end

endmodule

// File: rtl/stb_req_arbiter.sv
// -----------------------------------------------------------------------------
// stb_req_arbiter
// Round-robin arbiter sharing one axi_stb packet port between NUM_REQ
// burst_store requesters. The granted packet is captured, presented with a
// single-cycle stb2stb_valid pulse and held until stb2stb_done, after which
// the completion is routed back to the owner. A watchdog ends transactions
// whose completion never arrives and flags them with req_err.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/addr/data/burst_len/wstrb : flattened per-requester packets
//   req_ack             : one-hot pulse, packet captured
//   req_done            : one-hot pulse, transaction finished
//   req_err             : pulse with req_done on watchdog expiry
//   stb2stb_valid       : single-cycle packet pulse to axi_stb
//   stb2stb_addr/data/burst_len/wstrb : held payload
//   stb2stb_done        : completion pulse from axi_stb
//   busy                : transaction in flight (ISSUE or WAIT_DONE)
//   grant_id            : current / last granted requester
// -----------------------------------------------------------------------------
module stb_req_arbiter
    import stb_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 128,
    parameter int UR_BYTE_CNT    = 16,
    parameter int TIMEOUT_CYCLES = STB_TIMEOUT_DEFAULT,
    localparam int ID_W          = id_width(NUM_REQ)
) (
    input  logic                                 clk,
    input  logic                                 rst,

    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]        req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]        req_data,
    input  logic [NUM_REQ*STB_BURST_LEN_W-1:0]   req_burst_len,
    input  logic [NUM_REQ*UR_BYTE_CNT-1:0]       req_wstrb,
    output logic [NUM_REQ-1:0]                   req_ack,
    output logic [NUM_REQ-1:0]                   req_done,
    output logic [NUM_REQ-1:0]                   req_err,

    output logic                                 stb2stb_valid,
    output logic [ADDR_WIDTH-1:0]                stb2stb_addr,
    output logic [DATA_WIDTH-1:0]                stb2stb_data,
    output logic [STB_BURST_LEN_W-1:0]           stb2stb_burst_len,
    output logic [UR_BYTE_CNT-1:0]               stb2stb_wstrb,
    input  logic                                 stb2stb_done,

    output logic                                 busy,
    output logic [ID_W-1:0]                      grant_id
);

    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    // The counter starts at 0 on entry to WAIT_DONE, so expiry is decided
    // while it holds TIMEOUT_CYCLES-1 and the pulse lands TIMEOUT_CYCLES
    // cycles after entry.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    // ---------------------------------------------------------------------
    // Per-slot views of the flattened request buses
    // ---------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0]      slot_addr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]      slot_data  [NUM_REQ];
    logic [STB_BURST_LEN_W-1:0] slot_len   [NUM_REQ];
    logic [UR_BYTE_CNT-1:0]     slot_wstrb [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slot
            assign slot_addr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign slot_data[gi]  = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign slot_len[gi]   = req_burst_len[gi*STB_BURST_LEN_W +: STB_BURST_LEN_W];
            assign slot_wstrb[gi] = req_wstrb[gi*UR_BYTE_CNT +: UR_BYTE_CNT];
        end
    endgenerate

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    arb_state_e                 state_q,   state_d;
    logic [ID_W-1:0]            rr_ptr_q,  rr_ptr_d;
    logic [ID_W-1:0]            grant_q,   grant_d;
    logic [NUM_REQ-1:0]         ack_q,     ack_d;
    logic [NUM_REQ-1:0]         done_q,    done_d;
    logic [NUM_REQ-1:0]         err_q,     err_d;
    logic                       valid_q,   valid_d;
    logic [ADDR_WIDTH-1:0]      addr_q,    addr_d;
    logic [DATA_WIDTH-1:0]      data_q,    data_d;
    logic [STB_BURST_LEN_W-1:0] len_q,     len_d;
    logic [UR_BYTE_CNT-1:0]     wstrb_q,   wstrb_d;
    logic [WD_W-1:0]            wd_q,      wd_d;

    logic                       pick_found;
    logic [ID_W-1:0]            pick_winner;

    stb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .found     (pick_found),
        .winner    (pick_winner)
    );

    // ---------------------------------------------------------------------
    // Next-state / output logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        ack_d    = '0;
        done_d   = '0;
        err_d    = '0;
        valid_d  = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        len_d    = len_q;
        wstrb_d  = wstrb_q;
        wd_d     = wd_q;

        case (state_q)
            ST_IDLE: begin
                // A done arriving here belongs to nobody and is dropped.
                if (pick_found) begin
                    addr_d              = slot_addr[pick_winner];
                    data_d              = slot_data[pick_winner];
                    len_d               = slot_len[pick_winner];
                    wstrb_d             = slot_wstrb[pick_winner];
                    grant_d             = pick_winner;
                    rr_ptr_d            = pick_winner;
                    ack_d[pick_winner]  = 1'b1;
                    valid_d             = 1'b1;
                    state_d             = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                wd_d    = '0;
                state_d = ST_WAIT_DONE;
            end

            ST_WAIT_DONE: begin
                // Payload stays untouched: axi_stb re-reads data/wstrb
                // across its AW and W beats. A real completion beats a
                // simultaneous watchdog expiry.
                if (stb2stb_done) begin
                    done_d[grant_q] = 1'b1;
                    state_d         = ST_IDLE;
                end else if (wd_q == WD_LAST) begin
                    done_d[grant_q] = 1'b1;
                    err_d[grant_q]  = 1'b1;
                    state_d         = ST_IDLE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= ID_W'(NUM_REQ - 1);
            grant_q  <= '0;
            ack_q    <= '0;
            done_q   <= '0;
            err_q    <= '0;
            valid_q  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            len_q    <= '0;
            wstrb_q  <= '0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            ack_q    <= ack_d;
            done_q   <= done_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            len_q    <= len_d;
            wstrb_q  <= wstrb_d;
            wd_q     <= wd_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign req_ack           = ack_q;
    assign req_done          = done_q;
    assign req_err           = err_q;
    assign stb2stb_valid     = valid_q;
    assign stb2stb_addr      = addr_q;
    assign stb2stb_data      = data_q;
    assign stb2stb_burst_len = len_q;
    assign stb2stb_wstrb     = wstrb_q;
    assign grant_id          = grant_q;
    assign busy              = (state_q == ST_ISSUE) || (state_q == ST_WAIT_DONE);

endmodule

// File: tb/tb_stb_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_stb_req_arbiter
// Directed bench for stb_req_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=16). Inputs
// change 1 time unit after a rising edge; outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_stb_req_arbiter;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 128;
    localparam int SW = 16;
    localparam int LW = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR-1:0]    req_valid = '0;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR*LW-1:0] req_burst_len = '0;
    logic [NR*SW-1:0] req_wstrb = '0;
    logic [NR-1:0]    req_ack, req_done, req_err;
    logic             stb2stb_valid;
    logic [AW-1:0]    stb2stb_addr;
    logic [DW-1:0]    stb2stb_data;
    logic [LW-1:0]    stb2stb_burst_len;
    logic [SW-1:0]    stb2stb_wstrb;
    logic             stb2stb_done = 1'b0;
    logic             busy;
    logic [1:0]       grant_id;

    int checks = 0;
    int errors = 0;
    int b2b_cnt = 0;
    logic prev_valid = 1'b0;

    stb_req_arbiter #(
        .NUM_REQ        (NR),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .UR_BYTE_CNT    (SW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_addr          (req_addr),
        .req_data          (req_data),
        .req_burst_len     (req_burst_len),
        .req_wstrb         (req_wstrb),
        .req_ack           (req_ack),
        .req_done          (req_done),
        .req_err           (req_err),
        .stb2stb_valid     (stb2stb_valid),
        .stb2stb_addr      (stb2stb_addr),
        .stb2stb_data      (stb2stb_data),
        .stb2stb_burst_len (stb2stb_burst_len),
        .stb2stb_wstrb     (stb2stb_wstrb),
        .stb2stb_done      (stb2stb_done),
        .busy              (busy),
        .grant_id          (grant_id)
    );

    always #5 clk = ~clk;

    // stb2stb_valid must never be high in two consecutive cycles.
    always @(negedge clk) begin
        if (stb2stb_valid && prev_valid) b2b_cnt++;
        prev_valid = stb2stb_valid;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [LW-1:0] l, input logic [SW-1:0] s);
        req_addr[i*AW +: AW]      = a;
        req_data[i*DW +: DW]      = d;
        req_burst_len[i*LW +: LW] = l;
        req_wstrb[i*SW +: SW]     = s;
    endtask

    logic [DW-1:0] data_a;
    logic [DW-1:0] data_b;

    initial begin
        data_a = {4{32'hA5A5_0001}};
        data_b = {4{32'h5A5A_FFFE}};

        // ---------------- reset values ----------------
        tick(); tick();
        rst = 1'b0;
        chk("rst_valid", stb2stb_valid, 0);
        chk("rst_ack",   req_ack, 0);
        chk("rst_done",  req_done, 0);
        chk("rst_err",   req_err, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_gid",   grant_id, 0);
        chk("rst_addr",  stb2stb_addr, 0);

        // ---------------- single request on slot 2 ----------------
        set_slot(2, 32'h1000, 128'h1234, 8'd3, 16'hFFFF);
        req_valid[2] = 1'b1;
        tick();
        $display("txn single: grant %0d addr %0h", grant_id, stb2stb_addr);
        chk("s_ack",   req_ack, 4'b0100);
        chk("s_valid", stb2stb_valid, 1);
        chk("s_addr",  stb2stb_addr, 32'h1000);
        chk("s_len",   stb2stb_burst_len, 3);
        chk("s_gid",   grant_id, 2);
        chk("s_busy",  busy, 1);
        req_valid[2] = 1'b0;
        tick();
        chk("s_valid_low", stb2stb_valid, 0);
        chk("s_ack_low",   req_ack, 0);
        repeat (10) tick();
        stb2stb_done = 1'b1;
        tick();
        stb2stb_done = 1'b0;
        chk("s_done", req_done, 4'b0100);
        chk("s_err",  req_err, 0);
        chk("s_idle", busy, 0);
        tick();
        chk("s_done_pulse", req_done, 0);

        // ---------------- payload stability (slot 1) ----------------
        set_slot(1, 32'h2000, data_a, 8'd7, 16'h00FF);
        req_valid[1] = 1'b1;
        tick();
        $display("txn stable: grant %0d data %0h", grant_id, stb2stb_data);
        chk("p_ack",  req_ack, 4'b0010);
        chk("p_data", stb2stb_data, data_a);
        req_valid[1] = 1'b0;
        req_data[1*DW +: DW] = data_b;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("p_hold", stb2stb_data, data_a);
        end
        stb2stb_done = 1'b1;
        tick();
        stb2stb_done = 1'b0;
        chk("p_done", req_done, 4'b0010);
        chk("p_data_end", stb2stb_data, data_a);

        // ---------------- spurious done in IDLE ----------------
        stb2stb_done = 1'b1;
        tick();
        stb2stb_done = 1'b0;
        chk("sp_done", req_done, 0);
        chk("sp_busy", busy, 0);
        tick();
        chk("sp_done2", req_done, 0);

        // ---------------- watchdog expiry (slot 3) ----------------
        set_slot(3, 32'h3000, 128'h33, 8'd0, 16'h000F);
        req_valid[3] = 1'b1;
        tick();
        $display("txn watchdog: grant %0d", grant_id);
        chk("w_ack", req_ack, 4'b1000);
        req_valid[3] = 1'b0;
        repeat (16) tick();
        chk("w_early_done", req_done, 0);
        chk("w_early_busy", busy, 1);
        tick();
        chk("w_done", req_done, 4'b1000);
        chk("w_err",  req_err, 4'b1000);
        chk("w_idle", busy, 0);

        // next request still served after a timeout (slot 0), then done
        // coincident with the expiry cycle
        set_slot(0, 32'h4000, 128'h44, 8'd1, 16'h0003);
        req_valid[0] = 1'b1;
        tick();
        $display("txn coincident: grant %0d", grant_id);
        chk("c_ack", req_ack, 4'b0001);
        req_valid[0] = 1'b0;
        repeat (16) tick();
        stb2stb_done = 1'b1;
        tick();
        stb2stb_done = 1'b0;
        chk("c_done", req_done, 4'b0001);
        chk("c_err",  req_err, 0);

        // ---------------- reset during WAIT_DONE (slot 2) ----------------
        req_valid[2] = 1'b1;
        tick();
        $display("txn reset: grant %0d", grant_id);
        chk("r_ack", req_ack, 4'b0100);
        req_valid[2] = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("r_valid", stb2stb_valid, 0);
        chk("r_ack0",  req_ack, 0);
        chk("r_done0", req_done, 0);
        chk("r_busy",  busy, 0);
        chk("r_gid",   grant_id, 0);
        chk("r_data",  stb2stb_data, 0);
        stb2stb_done = 1'b1;   // late completion from the aborted transfer
        tick();
        stb2stb_done = 1'b0;
        chk("r_no_done", req_done, 0);

        // ---------------- fairness: all four continuously valid ----------------
        for (int i = 0; i < NR; i++)
            set_slot(i, 32'h100 * (i + 1), 128'(i), 8'(i), 16'h1 << i);
        req_valid = 4'b1111;
        for (int t = 0; t < 8; t++) begin
            tick();
            $display("txn rr %0d: grant %0d addr %0h", t, grant_id, stb2stb_addr);
            chk("f_gid",  grant_id, t % NR);
            chk("f_ack",  req_ack, 4'b0001 << (t % NR));
            chk("f_addr", stb2stb_addr, 32'h100 * ((t % NR) + 1));
            tick(); tick();
            stb2stb_done = 1'b1;
            tick();
            stb2stb_done = 1'b0;
            chk("f_done", req_done, 4'b0001 << (t % NR));
        end
        req_valid = '0;
        tick();
        chk("f_no_b2b", b2b_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
